rx_write_scheduler: RTL and testbench

RX_WRITE_SCHEDULER -- requirements
Module: rx_write_scheduler

---
 rtl/rx_sched_pkg.sv | 25 ++
 rtl/rx_write_scheduler_if.sv | 24 ++
 rtl/sat_counter16.sv | 26 ++
 rtl/rx_write_scheduler.sv | 103 ++++++++++
 tb/tb_rx_write_scheduler.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_sched_pkg.sv
// Shared types and helpers for the RX write scheduler: FSM states, the
// default FIFO guard margin and the frame word-count calculation.
package rx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_STALL = 2'd2
    } sched_state_t;

    localparam int MARGIN_DEFAULT = 4;

    // FIFO words needed for one frame. In 8-bit mode two channels share a
    // word, so an odd channel count rounds up. The result is clamped to 8
    // so an out-of-range channel count can never outrun the 3-bit word index.
    function automatic logic [3:0] calc_words(input logic [3:0] channels,
                                              input logic       mode8);
        logic [4:0] half_up;
        logic [3:0] words;
        half_up = {1'b0, channels} + 5'd1;
        words   = mode8 ? half_up[4:1] : channels;
        return (words > 4'd8) ? 4'd8 : words;
    endfunction

endpackage

// File: rtl/rx_write_scheduler_if.sv
// Sample-frame / FIFO-write bus between the receive datapath and the RX FIFO.
// The scheduler owns the write side (master); the datapath/FIFO side is slave.
interface rx_write_scheduler_if #(
    parameter int LVL_W = 12
);
    logic             rxstrobe;
    logic [3:0]       channels;
    logic             mode8;
    logic [LVL_W-1:0] wrusedw;
    logic             wrfull;
    logic             wrreq;
    logic [2:0]       sel;
    logic             first_word;

    modport master (
        input  rxstrobe, channels, mode8, wrusedw, wrfull,
        output wrreq, sel, first_word
    );

    modport slave (
        output rxstrobe, channels, mode8, wrusedw, wrfull,
        input  wrreq, sel, first_word
    );
endinterface

// File: rtl/sat_counter16.sv
// 16-bit event counter that saturates at all-ones. A clear coinciding with
// an increment leaves the count at 1 so the new event is not lost.
module sat_counter16 (
    input  logic        rxclk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] count
);

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    // Count update: reset, then clear (keeping a simultaneous event), then increment.
    always_ff @(posedge rxclk) begin
        if (reset) begin
            count <= 16'd0;
        end else if (clr) begin
            count <= inc ? 16'd1 : 16'd0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/rx_write_scheduler.sv
// Schedules the per-frame burst of FIFO writes for received sample frames.
// A frame is accepted only if the whole frame (plus a guard margin for
// wrusedw lag) fits in the FIFO; otherwise it is dropped and counted.
module rx_write_scheduler
    import rx_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 4096,
    parameter int LVL_W      = 12,
    parameter int MARGIN     = MARGIN_DEFAULT
) (
    input  logic                 rxclk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear_status,
    rx_write_scheduler_if.master bus,
    output logic                 busy,
    output logic                 overrun,
    output logic [15:0]          drop_count
);

    sched_state_t state;
    logic [2:0]   sel_q;
    logic [3:0]   words_q;

    logic [3:0]   words_new;
    logic [31:0]  space_need;
    logic         space_ok;
    logic         strobe_live;
    logic         write_now;
    logic         last_word;
    logic         accept;
    logic         drop;

    // Frame qualification: live strobe, space check, write and last-word detect.
    always_comb begin
        words_new   = calc_words(bus.channels, bus.mode8);
        space_need  = 32'(bus.wrusedw) + 32'(words_new) + 32'(MARGIN);
        space_ok    = !bus.wrfull && (space_need <= 32'(FIFO_DEPTH));
        strobe_live = bus.rxstrobe && enable && (words_new != 4'd0);
        write_now   = (state != ST_IDLE) && !bus.wrfull;
        last_word   = write_now && (({1'b0, sel_q} + 4'd1) == words_q);
        accept      = strobe_live && space_ok && ((state == ST_IDLE) || last_word);
        drop        = strobe_live && !accept;
    end

    // Write strobes decode the state; reset suppresses a write in the reset cycle itself.
    assign bus.wrreq      = write_now && !reset;
    assign bus.first_word = bus.wrreq && (sel_q == 3'd0);
    assign bus.sel        = sel_q;

    // Frame FSM: accept, write words in order, stall while the FIFO is full.
    always_ff @(posedge rxclk) begin
        if (reset) begin
            state   <= ST_IDLE;
            sel_q   <= 3'd0;
            words_q <= 4'd0;
            busy    <= 1'b0;
        end else if (accept) begin
            state   <= ST_WRITE;
            sel_q   <= 3'd0;
            words_q <= words_new;
            busy    <= 1'b1;
        end else begin
            case (state)
                ST_WRITE, ST_STALL: begin
                    if (bus.wrfull) begin
                        state <= ST_STALL;
                    end else if (last_word) begin
                        state <= ST_IDLE;
                        sel_q <= 3'd0;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_WRITE;
                        sel_q <= sel_q + 3'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overrun: a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge rxclk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clear_status) begin
            overrun <= 1'b0;
        end
    end

    sat_counter16 u_drop_counter (
        .rxclk (rxclk),
        .reset (reset),
        .clr   (clear_status),
        .inc   (drop),
        .count (drop_count)
    );

endmodule

// File: tb/tb_rx_write_scheduler.sv
// Self-checking bench for rx_write_scheduler: directed scenarios plus a
// randomized run, checked by a scoreboard fed from a frame-level model.
module tb_rx_write_scheduler;

    localparam int FIFO_DEPTH = 4096;
    localparam int LVL_W      = 12;
    localparam int MARGIN     = 4;

    logic        rxclk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clear_status = 1'b0;
    logic        busy;
    logic        overrun;
    logic [15:0] drop_count;

    rx_write_scheduler_if #(.LVL_W(LVL_W)) bus();

    rx_write_scheduler #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LVL_W      (LVL_W),
        .MARGIN     (MARGIN)
    ) dut (
        .rxclk        (rxclk),
        .reset        (reset),
        .enable       (enable),
        .clear_status (clear_status),
        .bus          (bus),
        .busy         (busy),
        .overrun      (overrun),
        .drop_count   (drop_count)
    );

    always #5 rxclk = ~rxclk;

    int cyc = 0;
    always @(posedge rxclk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_count = 0;

    typedef struct {
        int cyc;
        int sel;
        bit first;
    } wr_t;
    wr_t exp_q[$];
    wr_t e;

    // Stimulus levels held across cycles
    bit r_rst = 1'b1, r_en = 1'b1, r_m8 = 1'b0, r_full = 1'b0;
    int r_ch = 0, r_used = 0;

    // Frame-level model: words left in the current frame and next word index
    int m_rem = 0, m_sel = 0, m_drops = 0;
    bit m_ovr = 1'b0, m_valid = 1'b0;

    // Registered-output expectations visible during the current cycle
    bit s_busy = 1'b0, s_ovr = 1'b0, s_valid = 1'b0;
    int s_drops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: apply inputs just after the edge and advance the model.
    task automatic tick(input bit stb = 1'b0, input bit clr = 1'b0);
        int w;
        bit writing, last, live, fits, started, dropped;
        @(posedge rxclk);
        #1;
        s_busy  = (m_rem > 0);
        s_ovr   = m_ovr;
        s_drops = m_drops;
        s_valid = m_valid;
        reset        = r_rst;
        enable       = r_en;
        clear_status = clr;
        bus.rxstrobe = stb;
        bus.channels = r_ch[3:0];
        bus.mode8    = r_m8;
        bus.wrusedw  = r_used[LVL_W-1:0];
        bus.wrfull   = r_full;
        if (r_rst) begin
            m_rem = 0; m_sel = 0; m_ovr = 1'b0; m_drops = 0; m_valid = 1'b1;
            return;
        end
        w = r_m8 ? (r_ch + 1) / 2 : r_ch;
        if (w > 8) w = 8;
        writing = (m_rem > 0) && !r_full;
        if (writing) exp_q.push_back('{cyc, m_sel, (m_sel == 0)});
        last    = writing && (m_rem == 1);
        live    = stb && r_en && (w != 0);
        fits    = !r_full && (r_used + w + MARGIN <= FIFO_DEPTH);
        started = live && fits && ((m_rem == 0) || last);
        dropped = live && !started;
        if (started) begin
            m_rem = w; m_sel = 0;
        end else if (writing) begin
            m_rem--; m_sel++;
        end
        if (dropped) begin
            m_ovr   = 1'b1;
            m_drops = clr ? 1 : ((m_drops == 65535) ? 65535 : m_drops + 1);
        end else if (clr) begin
            m_ovr   = 1'b0;
            m_drops = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: compare status every cycle and pop an expected write whenever one is due.
    always @(negedge rxclk) begin
        if (s_valid) begin
            check("busy", busy, s_busy);
            check("overrun", overrun, s_ovr);
            check("drop_count", drop_count, s_drops);
            if (bus.wrreq === 1'b1) begin
                wr_count++;
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    check("wrreq_unexpected", bus.wrreq, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("sel", bus.sel, e.sel);
                    check("first_word", bus.first_word, e.first);
                end
            end else begin
                check("first_word_no_wr", bus.first_word, 1'b0);
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    check("wrreq_missing", bus.wrreq, 1'b1);
                end
            end
        end
    end

    int base;

    initial begin
        bus.rxstrobe = 1'b0;
        bus.channels = 4'd0;
        bus.mode8    = 1'b0;
        bus.wrusedw  = '0;
        bus.wrfull   = 1'b0;

        // Reset
        r_rst = 1'b1;
        idle(2);
        r_rst = 1'b0;
        tick();
        #1;
        check("rst_wrreq", bus.wrreq, 1'b0);
        check("rst_sel", bus.sel, 3'd0);
        check("rst_first", bus.first_word, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_drops", drop_count, 16'd0);

        // Four 16-bit channels: writes on the four cycles after the strobe
        r_ch = 4; r_m8 = 1'b0; r_used = 0;
        base = wr_count;
        tick(1'b1);
        tick();
        #1;
        check("f4_first_wrreq", bus.wrreq, 1'b1);
        check("f4_first_sel", bus.sel, 3'd0);
        check("f4_first_fw", bus.first_word, 1'b1);
        check("f4_busy", busy, 1'b1);
        idle(6);
        check("f4_writes", wr_count - base, 4);

        // 8-bit packing: 8 channels -> 4 words, 3 channels -> 2 words
        r_ch = 8; r_m8 = 1'b1;
        base = wr_count;
        tick(1'b1);
        idle(7);
        check("m8_ch8_writes", wr_count - base, 4);
        r_ch = 3;
        base = wr_count;
        tick(1'b1);
        idle(5);
        check("m8_ch3_writes", wr_count - base, 2);

        // No room: frame dropped, then status cleared
        r_ch = 8; r_m8 = 1'b0; r_used = 4086;
        base = wr_count;
        tick(1'b1);
        idle(3);
        check("full_writes", wr_count - base, 0);
        check("full_overrun", overrun, 1'b1);
        check("full_drops", drop_count, 16'd1);
        tick(1'b0, 1'b1);
        tick();
        #1;
        check("clr_overrun", overrun, 1'b0);
        check("clr_drops", drop_count, 16'd0);

        // Collision mid-frame, then a back-to-back strobe on the last write
        r_ch = 4; r_used = 0;
        base = wr_count;
        tick(1'b1);
        tick();
        tick(1'b1);
        tick();
        tick(1'b1);
        idle(6);
        check("b2b_writes", wr_count - base, 8);
        check("coll_drops", drop_count, 16'd1);
        tick(1'b0, 1'b1);

        // FIFO full for two cycles during a 4-word frame
        base = wr_count;
        tick(1'b1);
        tick();
        r_full = 1'b1;
        tick();
        #1;
        check("stall_wrreq", bus.wrreq, 1'b0);
        check("stall_sel", bus.sel, 3'd1);
        tick();
        r_full = 1'b0;
        idle(6);
        check("stall_writes", wr_count - base, 4);

        // Reset on the second word abandons the frame
        tick(1'b1);
        tick();
        r_rst = 1'b1;
        tick();
        #1;
        check("rst_mid_wrreq", bus.wrreq, 1'b0);
        r_rst = 1'b0;
        tick();
        #1;
        check("post_rst_wrreq", bus.wrreq, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_sel", bus.sel, 3'd0);
        base = wr_count;
        tick(1'b1);
        idle(6);
        check("post_rst_writes", wr_count - base, 4);

        // Strobes ignored while disabled or with zero channels
        r_en = 1'b0;
        tick(1'b1);
        r_en = 1'b1; r_ch = 0;
        tick(1'b1);
        idle(2);
        check("ignored_drops", drop_count, 16'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r_en   = ($urandom_range(0, 9) != 0);
            r_ch   = $urandom_range(0, 8);
            r_m8   = $urandom_range(0, 1);
            r_used = ($urandom_range(0, 3) == 0) ? 4096 - $urandom_range(1, 16) : $urandom_range(0, 4000);
            r_full = ($urandom_range(0, 9) == 0);
            r_rst  = ($urandom_range(0, 299) == 0);
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0);
        end
        r_rst = 1'b0; r_full = 1'b0; r_en = 1'b1;
        idle(12);

        // Saturation of the drop counter, then clear with a simultaneous drop
        r_ch = 8; r_m8 = 1'b0; r_used = 4095;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 65540; i++) tick(1'b1);
        tick();
        #1;
        check("sat_drops", drop_count, 16'hFFFF);
        tick(1'b1, 1'b1);
        tick();
        #1;
        check("clr_with_drop_drops", drop_count, 16'd1);
        check("clr_with_drop_ovr", overrun, 1'b1);
        idle(3);

        check("pending_writes", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
